// File: rtl/led_sequencer_if.sv
// Bus between status requesters and the LED sequencer.
//
// Handshake: a requester raises req[i] (level) with its flash count on
// code[i*CNT_W +: CNT_W] and holds it until ack[i] pulses for exactly one
// cycle. Dropping req[i] before that ack withdraws the request. code is
// sampled only in the grant cycle. busy/done/led/grant_id are status
// outputs of the sequencer.
interface led_sequencer_if #(
    parameter int NREQ  = 4,
    parameter int CNT_W = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]       req;
    logic [NREQ*CNT_W-1:0] code;
    logic [NREQ-1:0]       ack;
    logic [IDW-1:0]        grant_id;
    logic                  busy;
    logic                  done;
    logic                  led;

    modport master (
        output req, code,
        input  ack, grant_id, busy, done, led
    );

    modport slave (
        input  req, code,
        output ack, grant_id, busy, done, led
    );
endinterface

// File: rtl/led_sequencer.sv
// Arbitrated blink-code controller for the board status LED.
// Serves one requester at a time: N flashes (ON/OFF phases) then a GAP.
// Optional macro LED_SEQ_RR_EN selects round-robin arbitration; when it is
// undefined the lowest requesting index wins.
// All outputs are registered; state is exposed on state_o for debug.
module led_sequencer #(
    parameter int ON_CYCLES  = 1048576,
    parameter int OFF_CYCLES = 1048576,
    parameter int GAP_CYCLES = 4194304,
    parameter int NREQ       = 4,
    parameter int CNT_W      = 4
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    led_sequencer_if.slave bus,
    output logic [1:0]    state_o
);
    localparam int MAX_OG = (OFF_CYCLES > GAP_CYCLES) ? OFF_CYCLES : GAP_CYCLES;
    localparam int MAXC   = (ON_CYCLES > MAX_OG) ? ON_CYCLES : MAX_OG;
    localparam int CW     = $clog2(MAXC + 1);
    localparam int IDW    = $clog2(NREQ);

    // Phase counters count down to zero, so each phase loads length-1.
    localparam logic [CW-1:0] ON_LOAD  = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] OFF_LOAD = CW'(OFF_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2,
        S_GAP  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [IDW-1:0]     gid_q, gid_d;
    logic [NREQ-1:0]    ack_q, ack_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic               led_q, led_d;

    logic [IDW-1:0]     start_c;
    logic [2*NREQ-1:0]  rot_c;
    logic               win_vld_c;
    logic [IDW-1:0]     win_idx_c;
    logic [CNT_W-1:0]   win_code_c;

`ifdef LED_SEQ_RR_EN
    logic [IDW-1:0]     ptr_q, ptr_d;

    // Round-robin pointer: next search starts just after the last winner.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) ptr_q <= '0;
        else          ptr_q <= ptr_d;
    end

    // Next pointer value, advanced only on a grant.
    always_comb begin
        ptr_d = ptr_q;
        if (state_q == S_IDLE && win_vld_c) begin
            if (win_idx_c == IDW'(NREQ - 1)) ptr_d = '0;
            else                             ptr_d = win_idx_c + IDW'(1);
        end
    end
`endif

    // Arbiter: rotate requests so the search start sits at bit 0, take the
    // lowest set bit, then map back to the absolute index.
    always_comb begin
`ifdef LED_SEQ_RR_EN
        start_c = ptr_q;
`else
        start_c = '0;
`endif
        rot_c     = {bus.req, bus.req} >> start_c;
        win_vld_c = 1'b0;
        win_idx_c = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot_c[k]) begin
                win_vld_c = 1'b1;
                win_idx_c = IDW'((int'(start_c) + k) % NREQ);
            end
        end
        win_code_c = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_idx_c == IDW'(i)) win_code_c = bus.code[i*CNT_W +: CNT_W];
        end
    end

    // FSM next state, counters and the registered-output next values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        gid_d   = gid_q;
        ack_d   = '0;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (win_vld_c) begin
                    ack_d[win_idx_c] = 1'b1;
                    gid_d            = win_idx_c;
                    rem_d            = win_code_c;
                    if (win_code_c != '0) begin
                        state_d = S_ON;
                        cnt_d   = ON_LOAD;
                    end else begin
                        // Zero-flash code: acknowledged, only the gap runs.
                        state_d = S_GAP;
                        cnt_d   = GAP_LOAD;
                    end
                end
            end
            S_ON: begin
                if (cnt_q == '0) begin
                    rem_d = rem_q - CNT_W'(1);
                    // The last flash goes straight to the gap, no OFF phase.
                    if (rem_q == CNT_W'(1)) begin
                        state_d = S_GAP;
                        cnt_d   = GAP_LOAD;
                    end else begin
                        state_d = S_OFF;
                        cnt_d   = OFF_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_OFF: begin
                if (cnt_q == '0) begin
                    state_d = S_ON;
                    cnt_d   = ON_LOAD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
        led_d  = (state_d == S_ON);
    end

    // State, counters and registered outputs; reset clears everything,
    // dropping the LED at once and suppressing DONE for an aborted burst.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            gid_q   <= '0;
            ack_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            led_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            gid_q   <= gid_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            led_q   <= led_d;
        end
    end

    assign bus.ack      = ack_q;
    assign bus.grant_id = gid_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.led      = led_q;
    assign state_o      = state_q;
endmodule

// File: tb/tb_led_sequencer.sv
// Testbench for led_sequencer: randomized and directed requests checked
// cycle by cycle against a burst-level reference model.
module tb_led_sequencer;
    localparam int ON    = 4;
    localparam int OFF   = 3;
    localparam int GAP   = 8;
    localparam int NREQ  = 4;
    localparam int CNT_W = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] dbg_state;
    int         tests = 0;
    int         fails = 0;

    led_sequencer_if #(.NREQ(NREQ), .CNT_W(CNT_W)) bus ();

    led_sequencer #(
        .ON_CYCLES (ON),
        .OFF_CYCLES(OFF),
        .GAP_CYCLES(GAP),
        .NREQ      (NREQ),
        .CNT_W     (CNT_W)
    ) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .bus    (bus),
        .state_o(dbg_state)
    );

    // Clock.
    always #5 clk = ~clk;

    // Expected per-cycle outputs: {led, busy, done, ack[3:0], gid[1:0]}.
    logic [8:0] exp_q[$];
    int         mdl_ptr = 0;
    logic [1:0] mdl_gid = 2'd0;

    function automatic logic [8:0] mk(input logic led, input logic busy, input logic done,
                                      input logic [3:0] ack, input logic [1:0] gid);
        return {led, busy, done, ack, gid};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model reset: forget any in-flight burst.
    always @(negedge rst_n) begin
        exp_q.delete();
        mdl_ptr = 0;
        mdl_gid = 2'd0;
    end

    // Reference model: whenever no burst is outstanding and someone asks,
    // pick a winner and lay out the whole burst's waveform.
    always @(posedge clk) begin
        int w;
        int n;
        logic [3:0] a;
        if (rst_n && exp_q.size() == 0 && bus.req != '0) begin
            w = -1;
            for (int k = 0; k < NREQ; k++)
                if (w < 0 && bus.req[(mdl_ptr + k) % NREQ]) w = (mdl_ptr + k) % NREQ;
`ifdef LED_SEQ_RR_EN
            mdl_ptr = (w + 1) % NREQ;
`endif
            mdl_gid = w[1:0];
            n = int'(bus.code[w*CNT_W +: CNT_W]);
            a = 4'b0001 << w;
            for (int f = 0; f < n; f++) begin
                for (int c = 0; c < ON; c++)
                    exp_q.push_back(mk(1'b1, 1'b1, 1'b0, (exp_q.size() == 0) ? a : 4'b0, mdl_gid));
                if (f < n - 1)
                    for (int c = 0; c < OFF; c++)
                        exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 4'b0, mdl_gid));
            end
            for (int c = 0; c < GAP; c++)
                exp_q.push_back(mk(1'b0, 1'b1, 1'b0, (exp_q.size() == 0) ? a : 4'b0, mdl_gid));
            exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 4'b0, mdl_gid));
        end
    end

    // Monitor: compare every cycle's outputs with the next expected entry.
    always @(negedge clk) begin
        logic [8:0] e;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else                  e = mk(1'b0, 1'b0, 1'b0, 4'b0, mdl_gid);
        check("led",      bus.led,      e[8]);
        check("busy",     bus.busy,     e[7]);
        check("done",     bus.done,     e[6]);
        check("ack",      bus.ack,      e[5:2]);
        check("grant_id", bus.grant_id, e[1:0]);
    end

    // Driver tasks.
    task automatic run(input int n, input bit drop_on_ack);
        repeat (n) begin
            @(negedge clk);
            if (drop_on_ack) bus.req = bus.req & ~bus.ack;
        end
    endtask

    task automatic wait_idle(input int bound);
        int c = 0;
        while (exp_q.size() != 0 && c < bound) begin
            @(negedge clk);
            c++;
        end
        check("idle_timeout", (exp_q.size() == 0), 1);
        run(2, 1'b0);
    endtask

    task automatic wait_ack(input int idx, input int bound);
        int c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!bus.ack[idx] && c < bound);
        check("ack_timeout", bus.ack[idx], 1);
    endtask

    task automatic drain(input int bound);
        int c = 0;
        while (bus.req != '0 && c < bound) begin
            run(1, 1'b1);
            c++;
        end
        check("drain_timeout", (bus.req == '0), 1);
    endtask

    // Watchdog.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    // Stimulus.
    initial begin
        bus.req  = '0;
        bus.code = '0;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        run(2, 1'b0);

        // Single requester, 3 flashes.
        bus.code = 16'h0300;
        bus.req  = 4'b0100;
        drain(20);
        wait_idle(100);

        // Three simultaneous requests, each dropped on its ack.
        bus.code = 16'h2021;
        bus.req  = 4'b1011;
        drain(200);
        wait_idle(100);

        // Two requesters held continuously with one flash each.
        bus.code = 16'h0011;
        bus.req  = 4'b0011;
        run(4 * 13 + 2, 1'b0);
        bus.req = '0;
        wait_idle(100);

        // Zero-flash code.
        bus.code = 16'h0000;
        bus.req  = 4'b0010;
        drain(20);
        wait_idle(50);

        // Reset during the second ON phase of a 3-flash burst.
        bus.code = 16'h0003;
        bus.req  = 4'b0001;
        wait_ack(0, 20);
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_led",  bus.led,  0);
        check("async_busy", bus.busy, 0);
        check("async_done", bus.done, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_ack(0, 10);
        bus.req = '0;
        wait_idle(100);

        // Fifteen flashes; a late requester withdraws before the end.
        bus.code = 16'h00F0;
        bus.req  = 4'b0010;
        drain(20);
        run(20, 1'b0);
        bus.req[3] = 1'b1;
        run(50, 1'b0);
        bus.req[3] = 1'b0;
        wait_idle(200);

        // Randomized traffic.
        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < NREQ; i++) bus.code[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 4));
            bus.req = NREQ'($urandom_range(0, 15));
            run($urandom_range(5, 40), bit'($urandom_range(0, 1)));
        end
        bus.req = '0;
        wait_idle(300);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/led_sequencer.md
# led_sequencer

Arbitrated blink-code controller for the board status LED. Up to NREQ requesters each ask for a burst of N flashes and are served one at a time. Each burst is N flashes (ON/OFF phases) followed by an inter-code GAP. The block sits between status sources (PLL lock, USB state, error flags) and the top-level LED pin, replacing free-running blink counters.

## Interface
- ON_CYCLES, 1048576: LED-high length of one flash, in CLK cycles (≥1)
- OFF_CYCLES, 1048576: LED-low length between flashes of one code (≥1)
- GAP_CYCLES, 4194304: LED-low length after the last flash of a code (≥1)
- NREQ, 4: number of requesters (2..8)
- CNT_W, 4: width of each flash-count field
- CLK  in  1  system clock, all logic on posedge
- RST_N  in  1  reset; asynchronous, active-low
- REQ  in  NREQ  level request per requester; held until its ACK
- CODE  in  NREQ*CNT_W  flash count per requester, field i = CODE[i*CNT_W +: CNT_W], sampled at grant
- ACK  out  NREQ  one-cycle pulse on the granted requester's bit
- GRANT_ID  out  clog2(NREQ)  index of the current or last grant
- BUSY  out  1  high from the grant cycle through the last GAP cycle
- DONE  out  1  one-cycle pulse after a code completes
- LED  out  1  LED drive, active-high

## Operation
- States: IDLE, ON, OFF, GAP. Phase counter width = clog2(max(ON_CYCLES, OFF_CYCLES, GAP_CYCLES)+1). Remaining-flash register is CNT_W bits.
- IDLE: if any REQ bit is set, pick a winner, latch its CODE field into the remaining-flash register, set GRANT_ID, and pulse ACK[winner].
  - Code ≥1 → ON.
  - Code 0 → GAP directly. The request is acked with no flashes.
- ON: LED=1 for ON_CYCLES cycles. At the end, decrement remaining. If remaining>0 → OFF, else → GAP. The last flash has no OFF phase.
- OFF: LED=0 for OFF_CYCLES cycles, then → ON.
- GAP: LED=0 for GAP_CYCLES cycles, then → IDLE with DONE=1 for that one cycle.
- Arbitration is evaluated only in IDLE. REQ changes during ON/OFF/GAP are ignored until return to IDLE. A REQ dropped before ACK is never served. CODE is not re-sampled after the grant.
- Reset (RST_N low, any state, including mid-burst):
  - LED=0, ACK=0, DONE=0, BUSY=0, GRANT_ID=0, state=IDLE, counters=0, round-robin pointer=0.
  - An aborted burst produces no DONE.
  - Still-asserted REQs compete normally after release.

## Timing
- REQ seen high at posedge t in IDLE → ACK, BUSY, LED (if code≥1) all high from t+1. ACK lasts exactly one cycle.
- LED high exactly ON_CYCLES consecutive cycles per flash. LED low exactly OFF_CYCLES between flashes and exactly GAP_CYCLES after the last flash.
- BUSY duration for code N≥1: N·ON + (N−1)·OFF + GAP. For N=0: GAP.
- DONE cycle: BUSY=0, state=IDLE. The earliest next ACK is the following cycle, so there is a minimum 1 idle cycle between codes.
- All outputs are registered. No combinational path from REQ/CODE to outputs.

## Configuration
- LED_SEQ_RR_EN defined: round-robin arbitration.
  - Search starts at (last granted index + 1) mod NREQ.
  - Pointer is 0 after reset, so index 0 has first priority.
- LED_SEQ_RR_EN undefined: fixed priority, lowest index wins. The pointer logic is not built.

## Test plan
Bench parameters: ON=4, OFF=3, GAP=8, NREQ=4, CNT_W=4.
- REQ[2] held, CODE[2]=3 → ACK=4'b0100 for 1 cycle, GRANT_ID=2. LED runs 4H 3L 4H 3L 4H 8L. BUSY=26 cycles, then DONE pulses once.
- REQ=4'b1011 simultaneously, each dropped on its ACK → grants in order 0, 1, 3 (both modes), each burst separated by the DONE/idle cycle.
- REQ[0] and REQ[1] held continuously, CODE=1 each:
  - Without LED_SEQ_RR_EN → GRANT_ID stays 0 for every burst.
  - With it → grants alternate 0,1,0,1.
- CODE[1]=0 with REQ[1] → ACK[1], LED stays 0, BUSY=8 cycles, DONE.
- RST_N pulsed low during the second ON phase of a CODE=3 burst → LED=0 immediately without waiting for CLK, no DONE. After release, the still-held REQ is re-granted with a fresh full 3-flash burst.
- REQ[3] raised mid-burst and dropped before that burst's DONE → never acked. CODE=15 → 15 flashes, BUSY=110 cycles.
